// File: rtl/lsu_port_arbiter_if.sv
// Handshake bundle between issue-queue requesters, the shared LSU port and the arbiter.
// The slave view belongs to the arbiter; the master view is the surrounding pipeline.
interface lsu_port_arbiter_if #(
  parameter int REQ_COUNT = 2,
  parameter int REQ_W     = 32,
  parameter int RESP_W    = 32
);
  logic [REQ_COUNT-1:0]            req_valid_i;
  logic [REQ_COUNT-1:0][REQ_W-1:0] req_i;
  logic [REQ_COUNT-1:0]            req_ready_o;
  logic                            lsu_valid_o;
  logic [REQ_W-1:0]                lsu_req_o;
  logic                            lsu_ready_i;
  logic                            lsu_resp_valid_i;
  logic [RESP_W-1:0]               lsu_resp_i;
  logic                            lsu_resp_ready_o;
  logic [REQ_COUNT-1:0]            resp_valid_o;
  logic [RESP_W-1:0]               resp_o;
  logic [REQ_COUNT-1:0]            resp_ready_i;
  logic [7:0]                      drop_cnt_o;

  modport slave (
    input  req_valid_i, req_i, lsu_ready_i, lsu_resp_valid_i, lsu_resp_i, resp_ready_i,
    output req_ready_o, lsu_valid_o, lsu_req_o, lsu_resp_ready_o, resp_valid_o, resp_o,
           drop_cnt_o
  );

  modport master (
    output req_valid_i, req_i, lsu_ready_i, lsu_resp_valid_i, lsu_resp_i, resp_ready_i,
    input  req_ready_o, lsu_valid_o, lsu_req_o, lsu_resp_ready_o, resp_valid_o, resp_o,
           drop_cnt_o
  );
endinterface

// File: rtl/lsu_port_arbiter.sv
// Round-robin arbiter sharing one LSU port among issue-queue requesters, with an
// order FIFO that routes in-order LSU responses back to the requester that issued them.
module lsu_port_arbiter #(
  parameter int REQ_COUNT   = 2,
  parameter int ORDER_DEPTH = 4,
  parameter int REQ_W       = 32,
  parameter int RESP_W      = 32
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  lsu_port_arbiter_if.slave bus
);

  localparam int GW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int PW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [GW-1:0] rr_ptr;
  logic          lock;
  logic [GW-1:0] lock_g;
  logic [GW-1:0] order_mem [ORDER_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    drop_cnt;

  logic [GW-1:0] grant;
  logic [GW-1:0] head;
  logic [GW:0]   scan_sum;
  logic          found;
  logic          empty;
  logic          full;
  logic          lsu_valid;
  logic          push;
  logic          pop;
  logic          drop;

  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_sum = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      scan_sum = {1'b0, rr_ptr} + (GW+1)'(i);
      if (scan_sum >= (GW+1)'(REQ_COUNT)) scan_sum = scan_sum - (GW+1)'(REQ_COUNT);
      if (!found && bus.req_valid_i[scan_sum[GW-1:0]]) begin
        found = 1'b1;
        grant = scan_sum[GW-1:0];
      end
    end
    // A stalled request keeps its grant until the LSU takes it.
    if (lock) begin
      grant = lock_g;
      found = bus.req_valid_i[lock_g];
    end

    empty = (count == '0);
    head  = order_mem[rd_ptr];
    pop   = !flush && !empty && bus.lsu_resp_valid_i && bus.resp_ready_i[head];
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    full  = (count == CW'(ORDER_DEPTH)) && !pop;
    lsu_valid = found && !full && !flush;
    push  = lsu_valid && bus.lsu_ready_i;
    drop  = !flush && empty && bus.lsu_resp_valid_i;

    bus.lsu_valid_o = lsu_valid;
    bus.lsu_req_o   = bus.req_i[grant];
    bus.req_ready_o = '0;
    if (push) bus.req_ready_o[grant] = 1'b1;

    bus.resp_valid_o = '0;
    if (!empty && !flush) bus.resp_valid_o[head] = bus.lsu_resp_valid_i;
    bus.lsu_resp_ready_o = empty ? 1'b1 : bus.resp_ready_i[head];
    bus.resp_o           = bus.lsu_resp_i;
    bus.drop_cnt_o       = drop_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_g   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
      lock   <= 1'b0;
      lock_g <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        lock   <= 1'b0;
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant == GW'(REQ_COUNT - 1)) ? '0 : grant + 1'b1;
      end else if (lsu_valid) begin
        lock   <= 1'b1;
        lock_g <= grant;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) order_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Scenario bench for lsu_port_arbiter: granted requester ids are queued on acceptance
// and popped to check response routing.
module tb_lsu_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];
  int ord_q[$];
  logic [15:0] tag = '0;

  always #5 clk = ~clk;

  lsu_port_arbiter_if #(.REQ_COUNT(2), .REQ_W(16), .RESP_W(16)) bus ();

  lsu_port_arbiter #(.REQ_COUNT(2), .ORDER_DEPTH(4), .REQ_W(16), .RESP_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  function automatic logic [15:0] pay(input int g, input logic [15:0] t);
    return ((g == 1) ? 16'hB000 : 16'hA000) + t;
  endfunction

  function automatic logic [1:0] onehot(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic rdy);
    tag = tag + 16'd1;
    bus.req_valid_i = v;
    bus.req_i[0] = pay(0, tag);
    bus.req_i[1] = pay(1, tag);
    bus.lsu_ready_i = rdy;
    #1;
  endtask

  task automatic idle();
    bus.req_valid_i = '0;
    bus.lsu_ready_i = 1'b0;
    bus.lsu_resp_valid_i = 1'b0;
    bus.lsu_resp_i = '0;
    bus.resp_ready_i = 2'b11;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    ord_q.delete();
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.lsu_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_lsu_valid got %b want 0", bus.lsu_valid_o); end
    tests_run++; if (bus.req_ready_o !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready_o); end
    tests_run++; if (bus.resp_valid_o !== 2'b00) begin tests_failed++; $display("FAIL reset_resp_valid got %b want 00", bus.resp_valid_o); end
    tests_run++; if (bus.lsu_resp_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_lsu_resp_ready got %b want 1", bus.lsu_resp_ready_o); end
    tests_run++; if (bus.drop_cnt_o !== 8'd0) begin tests_failed++; $display("FAIL reset_drop_cnt got %0d want 0", bus.drop_cnt_o); end
  endtask

  // Drains every outstanding entry of ord_q, checking the routing of each response.
  task automatic test_response_order();
    int h;
    int n;
    bus.req_valid_i = '0;
    bus.resp_ready_i = 2'b11;
    bus.lsu_resp_valid_i = 1'b1;
    n = ord_q.size();
    for (int k = 0; k < n; k++) begin
      bus.lsu_resp_i = 16'hC000 + 16'(k);
      #1;
      h = ord_q.pop_front();
      tests_run++; if (bus.resp_valid_o !== onehot(h)) begin tests_failed++; $display("FAIL resp_route[%0d] got %b want %b", k, bus.resp_valid_o, onehot(h)); end
      tests_run++; if (bus.resp_o !== 16'hC000 + 16'(k)) begin tests_failed++; $display("FAIL resp_payload[%0d] got %h want %h", k, bus.resp_o, 16'hC000 + 16'(k)); end
      tests_run++; if (bus.lsu_resp_ready_o !== 1'b1) begin tests_failed++; $display("FAIL resp_ready[%0d] got %b want 1", k, bus.lsu_resp_ready_o); end
      tick();
    end
    bus.lsu_resp_valid_i = 1'b0;
    #1;
    tests_run++; if (bus.resp_valid_o !== 2'b00 || bus.lsu_resp_ready_o !== 1'b1) begin tests_failed++; $display("FAIL drained_empty got valid=%b ready=%b want 00/1", bus.resp_valid_o, bus.lsu_resp_ready_o); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(k % 2);
    for (int k = 0; k < 4; k++) begin
      set_req(2'b11, 1'b1);
      g = exp_q.pop_front();
      tests_run++; if (bus.lsu_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rr_valid[%0d] got %b want 1", k, bus.lsu_valid_o); end
      tests_run++; if (bus.req_ready_o !== onehot(g)) begin tests_failed++; $display("FAIL rr_grant[%0d] got %b want %b", k, bus.req_ready_o, onehot(g)); end
      tests_run++; if (bus.lsu_req_o !== pay(g, tag)) begin tests_failed++; $display("FAIL rr_payload[%0d] got %h want %h", k, bus.lsu_req_o, pay(g, tag)); end
      ord_q.push_back(g);
      tick();
    end
  endtask

  // Continues from the four accepted requests of test_round_robin.
  task automatic test_full();
    set_req(2'b11, 1'b1);
    tests_run++; if (bus.lsu_valid_o !== 1'b0) begin tests_failed++; $display("FAIL full_valid got %b want 0", bus.lsu_valid_o); end
    tests_run++; if (bus.req_ready_o !== 2'b00) begin tests_failed++; $display("FAIL full_ready got %b want 00", bus.req_ready_o); end
    tick();
    tests_run++; if (bus.lsu_valid_o !== 1'b0) begin tests_failed++; $display("FAIL full_hold_valid got %b want 0", bus.lsu_valid_o); end
    bus.lsu_resp_valid_i = 1'b1;
    bus.lsu_resp_i = 16'hC0FF;
    #1;
    tests_run++; if (bus.resp_valid_o !== onehot(ord_q[0])) begin tests_failed++; $display("FAIL full_pop_route got %b want %b", bus.resp_valid_o, onehot(ord_q[0])); end
    tests_run++; if (bus.lsu_valid_o !== 1'b1) begin tests_failed++; $display("FAIL full_pop_valid got %b want 1", bus.lsu_valid_o); end
    tests_run++; if (bus.req_ready_o !== 2'b01) begin tests_failed++; $display("FAIL full_pop_accept got %b want 01", bus.req_ready_o); end
    tick();
    void'(ord_q.pop_front());
    ord_q.push_back(0);
    bus.lsu_resp_valid_i = 1'b0;
    test_response_order();
  endtask

  task automatic test_lock();
    do_reset();
    set_req(2'b01, 1'b1);
    tests_run++; if (bus.req_ready_o !== 2'b01) begin tests_failed++; $display("FAIL lock_pre got %b want 01", bus.req_ready_o); end
    ord_q.push_back(0);
    tick();
    set_req(2'b01, 1'b0);
    tests_run++; if (bus.lsu_valid_o !== 1'b1 || bus.req_ready_o !== 2'b00) begin tests_failed++; $display("FAIL lock_stall got valid=%b ready=%b want 1/00", bus.lsu_valid_o, bus.req_ready_o); end
    tick();
    for (int k = 0; k < 2; k++) begin
      set_req(2'b11, 1'b0);
      tests_run++; if (bus.lsu_req_o !== pay(0, tag)) begin tests_failed++; $display("FAIL lock_hold[%0d] got %h want %h", k, bus.lsu_req_o, pay(0, tag)); end
      tests_run++; if (bus.req_ready_o !== 2'b00) begin tests_failed++; $display("FAIL lock_ready[%0d] got %b want 00", k, bus.req_ready_o); end
      tick();
    end
    set_req(2'b11, 1'b1);
    tests_run++; if (bus.req_ready_o !== 2'b01) begin tests_failed++; $display("FAIL lock_release got %b want 01", bus.req_ready_o); end
    ord_q.push_back(0);
    tick();
    set_req(2'b11, 1'b1);
    tests_run++; if (bus.req_ready_o !== 2'b10 || bus.lsu_req_o !== pay(1, tag)) begin tests_failed++; $display("FAIL lock_next got ready=%b req=%h want 10/%h", bus.req_ready_o, bus.lsu_req_o, pay(1, tag)); end
    ord_q.push_back(1);
    tick();
    test_response_order();
  endtask

  task automatic test_order();
    logic [1:0] vals [3] = '{2'b10, 2'b01, 2'b10};
    int gs [3] = '{1, 0, 1};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(vals[k], 1'b1);
      tests_run++; if (bus.req_ready_o !== onehot(gs[k])) begin tests_failed++; $display("FAIL order_accept[%0d] got %b want %b", k, bus.req_ready_o, onehot(gs[k])); end
      ord_q.push_back(gs[k]);
      tick();
    end
    idle();
    bus.resp_ready_i = 2'b01;
    bus.lsu_resp_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++; if (bus.resp_valid_o !== 2'b10 || bus.lsu_resp_ready_o !== 1'b0) begin tests_failed++; $display("FAIL order_stall[%0d] got valid=%b ready=%b want 10/0", k, bus.resp_valid_o, bus.lsu_resp_ready_o); end
      tick();
    end
    test_response_order();
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_req(2'b01, 1'b1);
      tests_run++; if (bus.req_ready_o !== 2'b01) begin tests_failed++; $display("FAIL flush_pre[%0d] got %b want 01", k, bus.req_ready_o); end
      tick();
    end
    flush = 1'b1;
    bus.lsu_resp_valid_i = 1'b1;
    set_req(2'b11, 1'b1);
    tests_run++; if (bus.lsu_valid_o !== 1'b0 || bus.req_ready_o !== 2'b00) begin tests_failed++; $display("FAIL flush_cycle_req got valid=%b ready=%b want 0/00", bus.lsu_valid_o, bus.req_ready_o); end
    tests_run++; if (bus.resp_valid_o !== 2'b00) begin tests_failed++; $display("FAIL flush_cycle_resp got %b want 00", bus.resp_valid_o); end
    tick();
    idle();
    bus.lsu_resp_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++; if (bus.resp_valid_o !== 2'b00 || bus.lsu_resp_ready_o !== 1'b1) begin tests_failed++; $display("FAIL flush_orphan[%0d] got valid=%b ready=%b want 00/1", k, bus.resp_valid_o, bus.lsu_resp_ready_o); end
      tick();
    end
    bus.lsu_resp_valid_i = 1'b0;
    #1;
    tests_run++; if (bus.drop_cnt_o !== 8'd2) begin tests_failed++; $display("FAIL flush_drop_cnt got %0d want 2", bus.drop_cnt_o); end
    set_req(2'b11, 1'b1);
    tests_run++; if (bus.req_ready_o !== 2'b01) begin tests_failed++; $display("FAIL flush_rr_reset got %b want 01", bus.req_ready_o); end
    ord_q.push_back(0);
    tick();
    test_response_order();
  endtask

  task automatic test_saturate();
    do_reset();
    bus.lsu_resp_valid_i = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    tests_run++; if (bus.drop_cnt_o !== 8'd100) begin tests_failed++; $display("FAIL drop_100 got %0d want 100", bus.drop_cnt_o); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++; if (bus.drop_cnt_o !== 8'd100) begin tests_failed++; $display("FAIL drop_flush_hold got %0d want 100", bus.drop_cnt_o); end
    for (int k = 0; k < 200; k++) tick();
    tests_run++; if (bus.drop_cnt_o !== 8'd255) begin tests_failed++; $display("FAIL drop_saturate got %0d want 255", bus.drop_cnt_o); end
    do_reset();
    tests_run++; if (bus.drop_cnt_o !== 8'd0) begin tests_failed++; $display("FAIL drop_reset got %0d want 0", bus.drop_cnt_o); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_round_robin();
    test_full();
    test_lock();
    test_order();
    test_flush();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
